// File: rtl/xs3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | xs3_pkg : shared constants and state encoding for xs3_to_bin_seq   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package xs3_pkg;

  localparam int NDIG_DEF   = 4;
  localparam int OUT_W_DEF  = 14;

  localparam int XS3_OFFSET = 3;
  localparam int XS3_MIN    = 3;
  localparam int XS3_MAX    = 12;
  localparam int BCD_MAX    = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/xs3_digit_dec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | xs3_digit_dec : one excess-3 / BCD digit to its value + invalid    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] code,
  input  logic       mode,
  output logic [3:0] value,
  output logic       invalid
);

  // Invalid digits contribute zero so the accumulator stays well defined.
  always_comb begin
    value   = 4'd0;
    invalid = 1'b0;
    if (mode) begin
      invalid = (code > 4'(BCD_MAX));
      value   = invalid ? 4'd0 : code;
    end else begin
      invalid = (code < 4'(XS3_MIN)) || (code > 4'(XS3_MAX));
      value   = invalid ? 4'd0 : (code - 4'(XS3_OFFSET));
    end
  end

endmodule
`default_nettype wire

// File: rtl/xs3_to_bin_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | xs3_to_bin_seq : serial MSD-first excess-3/BCD to binary converter |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module xs3_to_bin_seq
  import xs3_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] code_in,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  bin_out,
  output logic              err,
  output logic              busy
);

  localparam int                CNT_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NDIG - 1);

  state_t             r_state;
  logic [4*NDIG-1:0]  r_word;
  logic               r_mode;
  logic [CNT_W-1:0]   r_cnt;
  logic [OUT_W-1:0]   r_acc;
  logic               r_err_acc;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [OUT_W-1:0]   r_bin;
  logic               r_err;

  logic [3:0]         w_val;
  logic               w_inv;
  logic [OUT_W-1:0]   w_next;

  // The captured word shifts left each digit, so the top nibble is always current.
  xs3_digit_dec u_dec (
    .code    (r_word[4*NDIG-1 -: 4]),
    .mode    (r_mode),
    .value   (w_val),
    .invalid (w_inv)
  );

  assign w_next = OUT_W'(r_acc * OUT_W'(10)) + OUT_W'(w_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_err_acc   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_bin       <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_word     <= code_in;
            r_mode     <= mode;
            r_acc      <= '0;
            r_err_acc  <= 1'b0;
            r_cnt      <= LAST_IDX;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= CONV;
          end
        end
        CONV: begin
          r_acc     <= w_next;
          r_err_acc <= r_err_acc | w_inv;
          r_word    <= r_word << 4;
          r_cnt     <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_bin       <= w_next;
            r_err       <= r_err_acc | w_inv;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // in_ready returns the cycle after the drain, never alongside it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bin_out   = r_bin;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_xs3_to_bin_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_xs3_to_bin_seq : directed self-checking bench, NDIG=4 OUT_W=14  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_xs3_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] code_in = 16'h0000;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] bin_out;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  xs3_to_bin_seq #(.NDIG(4), .OUT_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code_in   (code_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Offer one word, scramble inputs during conversion, check latency and result.
  task automatic convert(input string tag, input logic [15:0] code, input logic md,
                         input logic [13:0] exp_bin, input logic exp_err, input logic drain);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    code_in  = code;
    mode     = md;
    @(posedge clk); #1;
    code_in  = ~code;
    mode     = ~md;
    k = 0;
    @(negedge clk);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!out_valid && k < 20) begin
      @(posedge clk); k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, k, 32'd4);
    check({tag, "_bin"}, {18'd0, bin_out}, {18'd0, exp_bin});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_drain_ov"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_drain_rdy"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_hold_bin"}, {18'd0, bin_out}, {18'd0, exp_bin});
    end
  endtask

  initial begin
    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    check("rst_rdy",  {31'd0, in_ready},  32'd0);
    check("rst_ov",   {31'd0, out_valid}, 32'd0);
    check("rst_bin",  {18'd0, bin_out},   32'd0);
    check("rst_err",  {31'd0, err},       32'd0);
    check("rst_busy", {31'd0, busy},      32'd0);
    rst = 1'b0;
    #1;
    check("rel_rdy0", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_rdy1", {31'd0, in_ready}, 32'd1);

    convert("xs3_4567", 16'h789A, 1'b0, 14'd4567, 1'b0, 1'b1);
    convert("xs3_zero", 16'h3333, 1'b0, 14'd0,    1'b0, 1'b1);
    convert("xs3_9999", 16'hCCCC, 1'b0, 14'h270F, 1'b0, 1'b1);
    convert("xs3_bad",  16'h4F45, 1'b0, 14'd1012, 1'b1, 1'b1);
    convert("bcd_1234", 16'h1234, 1'b1, 14'd1234, 1'b0, 1'b1);
    convert("bcd_bad",  16'h12A4, 1'b1, 14'd1204, 1'b1, 1'b1);

    // Hold in DONE with out_ready low while the input side churns.
    convert("hold", 16'h789A, 1'b0, 14'd4567, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      code_in  = 16'h1111 * 16'(i);
      mode     = i[1];
      @(negedge clk);
      check("hold_ov",   {31'd0, out_valid}, 32'd1);
      check("hold_bin",  {18'd0, bin_out},   32'd4567);
      check("hold_err",  {31'd0, err},       32'd0);
      check("hold_rdy",  {31'd0, in_ready},  32'd0);
      check("hold_busy", {31'd0, busy},      32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("hold_drain_ov",  {31'd0, out_valid}, 32'd0);
    check("hold_drain_rdy", {31'd0, in_ready},  32'd1);
    check("hold_drain_bsy", {31'd0, busy},      32'd0);

    // Reset asserted in the second CONV cycle aborts the word.
    in_valid = 1'b1;
    code_in  = 16'h789A;
    mode     = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_ov",   {31'd0, out_valid}, 32'd0);
    check("abort_bin",  {18'd0, bin_out},   32'd0);
    check("abort_rdy",  {31'd0, in_ready},  32'd0);
    check("abort_busy", {31'd0, busy},      32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_nov", {31'd0, out_valid}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("abort_rel0", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("abort_rel1", {31'd0, in_ready}, 32'd1);
    convert("post_rst", 16'h1234, 1'b1, 14'd1234, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/xs3_to_bin_seq.md
XS3_TO_BIN_SEQ -- requirements
Module: xs3_to_bin_seq

Interface
REQ-001 SHALL have parameter NDIG, default 4, giving the number of 4-bit digits per input word (range 1..8).
REQ-002 SHALL have parameter OUT_W, default 14, giving the binary result width; the legal range is OUT_W >= ceil(log2(10^NDIG)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input word is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port code_in, input, 4*NDIG bits: packed digits, most significant digit in the top nibble.
REQ-008 SHALL have port mode, input, 1 bit: 0 = excess-3 digits, 1 = plain BCD digits; sampled at acceptance.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port bin_out, output, OUT_W bits: the unsigned binary value.
REQ-012 SHALL have port err, output, 1 bit: at least one digit in the word was invalid; qualified by out_valid.
REQ-013 SHALL have port busy, output, 1 bit: high in CONV and DONE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-015 SHALL, in IDLE, drive in_ready=1; on in_valid&in_ready, capture code_in and mode, clear the accumulator and err, load the digit counter with NDIG-1, and go to CONV.
REQ-016 SHALL, in each CONV cycle, process one digit MSD-first: acc <= acc*10 + digit_value, with the result truncated to OUT_W bits.
REQ-017 SHALL decode digits as follows: mode 0 gives value = code-3 and is valid for codes 0011..1100; mode 1 gives value = code and is valid for codes 0000..1001.
REQ-018 SHALL treat an invalid digit as value 0 and set err, which stays sticky for the rest of the transaction.
REQ-019 SHALL leave CONV for DONE after NDIG digits, so out_valid rises exactly NDIG clock edges after the accepting edge.
REQ-020 SHALL, in DONE, hold out_valid, bin_out and err stable until out_ready=1.
REQ-021 SHALL, on out_valid&out_ready, return to IDLE; in_ready reasserts on the following cycle, with no same-cycle accept-on-drain.
REQ-022 SHALL ignore in_valid, code_in and mode outside IDLE; a word changing mid-conversion has no effect.
REQ-023 SHALL clear out_valid, but not bin_out/err, outside DONE; bin_out holds its last result.

Reset
REQ-024 SHALL, while rst=1 (asynchronously), force state=IDLE and in_ready=0, out_valid=0, bin_out=0, err=0, busy=0.
REQ-025 SHALL raise in_ready on the first rising clk edge after rst deasserts.
REQ-026 SHALL, when rst asserts mid-CONV or mid-DONE, abort the transaction; no partial result is ever flagged valid.

Structure
REQ-027 SHALL take its state encoding (IDLE/CONV/DONE), the XS3_OFFSET=3 constant, the XS3_MIN=3/XS3_MAX=12/BCD_MAX=9 limits and the NDIG/OUT_W defaults from a shared package xs3_pkg.
REQ-028 SHALL contain exactly one sub-module, xs3_digit_dec (combinational: 4-bit code + mode -> 4-bit value + invalid flag), instantiated once on the selected digit.

Verification
REQ-029 SHALL be checked with NDIG=4, mode=0, code_in=16'h789A -> bin_out=14'd4567, err=0, out_valid 4 edges after accept.
REQ-030 SHALL be checked with mode=0, 16'h3333 -> 0, and 16'hCCCC -> 9999 (14'h270F), both err=0 (boundary codes).
REQ-031 SHALL be checked with mode=0, 16'h4F45 -> bin_out=1012, err=1; then mode=1, 16'h1234 -> 1234, err=0 (err cleared per transaction).
REQ-032 SHALL be checked with mode=1, 16'h12A4 -> bin_out=1204, err=1.
REQ-033 SHALL be checked with out_ready held 0 for 10 cycles in DONE while toggling in_valid/code_in -> out_valid, bin_out and err constant, in_ready=0, busy=1; result accepted when out_ready rises.
REQ-034 SHALL be checked with rst pulsed during the 2nd CONV cycle -> outputs zero immediately, no out_valid, in_ready=1 one edge after release, and the next word converts correctly.
